// File: rtl/dmem_responder.sv
// dmem_responder: slave end of the MEM-stage load/store port.
// Accepts one read or byte-masked write per handshake, waits a programmable number of
// cycles, then presents read data or a write acknowledgement until the MEM stage takes it.
// Addresses outside [BASE_ADDR, BASE_ADDR + 8*DEPTH) complete with resp_err_o set and
// never touch the array.
module dmem_responder #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wen_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  input  logic [7:0]  req_wmask_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [63:0] resp_rdata_o,
  output logic        resp_err_o
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  // Counter preload: WAIT spends LATENCY-1 cycles before RESP.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam bit               SINGLE_CYCLE = (LATENCY == 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Out-of-range check done in full 64-bit arithmetic: an address below the base
  // is caught explicitly, so the wrapped subtraction can never alias into the array.
  function automatic logic addr_err(input logic [63:0] addr);
    return (addr < BASE_ADDR) || (((addr - BASE_ADDR) >> 6'd3) >= 64'(DEPTH));
  endfunction

  // Word index into the array; only meaningful when addr_err() is 0.
  function automatic logic [IDX_W-1:0] addr_index(input logic [63:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> 6'd3);
  endfunction

  // Replace only the byte lanes whose mask bit is set.
  function automatic logic [63:0] merge_lanes(input logic [63:0] old_word,
                                              input logic [63:0] new_word,
                                              input logic [7:0]  mask);
    logic [63:0] res;
    res = old_word;
    for (int k = 0; k < 8; k++) begin
      if (mask[k]) begin
        res[8*k +: 8] = new_word[8*k +: 8];
      end else begin
        res[8*k +: 8] = old_word[8*k +: 8];
      end
    end
    return res;
  endfunction

  // Storage: not reset, so contents survive rst.
  logic [63:0] mem_q [DEPTH];

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic [63:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              accept_s;
  logic              req_err_s;
  logic [IDX_W-1:0]  req_idx_s;
  logic [63:0]       mem_rd_s;
  logic              mem_we_s;

  // Decode the presented request: range check, word index and current array word.
  always_comb begin
    accept_s  = req_valid_i && ready_q;
    req_err_s = addr_err(req_addr_i);
    req_idx_s = addr_index(req_addr_i);
    mem_rd_s  = mem_q[req_idx_s];
  end

  // Next-state logic, latency counter and response register updates.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    mem_we_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          err_d    = req_err_s;
          mem_we_s = req_wen_i && !req_err_s;
          if (req_wen_i || req_err_s) begin
            rdata_d = 64'h0;
          end else begin
            rdata_d = mem_rd_s;
          end
          if (SINGLE_CYCLE) begin
            state_d = ST_RESP;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end
      end

      ST_WAIT: begin
        if (cnt_q <= CNT_ONE) begin
          state_d = ST_RESP;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = cnt_q - CNT_ONE;
        end
      end

      ST_RESP: begin
        if (resp_ready_i) begin
          state_d = ST_IDLE;
          rdata_d = 64'h0;
          err_d   = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
        rdata_d = 64'h0;
        err_d   = 1'b0;
      end
    endcase

    // Handshake flags are registered copies of the next state so the ports come from flops.
    ready_d = (state_d == ST_IDLE);
    valid_d = (state_d == ST_RESP);
  end

  // Control and response registers; ready stays low while rst is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= 64'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array write: committed at the accepting edge, masked per byte lane.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[req_idx_s] <= merge_lanes(mem_rd_s, req_wdata_i, req_wmask_i);
    end
  end

  assign req_ready_o  = ready_q;
  assign resp_valid_o = valid_q;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized traffic, checked against a
// word-indexed associative-array memory model. Instance a uses LATENCY=2, instance b
// uses LATENCY=1 for the back-to-back throughput scenario.
module tb_dmem_responder;

  localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
  localparam int unsigned DEPTH = 1024;
  localparam int          LAT_A = 2;
  localparam int          LAT_B = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid_a, req_ready_a, req_wen_a, resp_valid_a, resp_ready_a, resp_err_a;
  logic [63:0] req_addr_a, req_wdata_a, resp_rdata_a;
  logic [7:0]  req_wmask_a;
  logic        req_valid_b, req_ready_b, req_wen_b, resp_valid_b, resp_ready_b, resp_err_b;
  logic [63:0] req_addr_b, req_wdata_b, resp_rdata_b;
  logic [7:0]  req_wmask_b;

  dmem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(LAT_A)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_a), .req_ready_o(req_ready_a), .req_wen_i(req_wen_a),
    .req_addr_i(req_addr_a), .req_wdata_i(req_wdata_a), .req_wmask_i(req_wmask_a),
    .resp_valid_o(resp_valid_a), .resp_ready_i(resp_ready_a),
    .resp_rdata_o(resp_rdata_a), .resp_err_o(resp_err_a)
  );

  dmem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(LAT_B)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_b), .req_ready_o(req_ready_b), .req_wen_i(req_wen_b),
    .req_addr_i(req_addr_b), .req_wdata_i(req_wdata_b), .req_wmask_i(req_wmask_b),
    .resp_valid_o(resp_valid_b), .resp_ready_i(resp_ready_b),
    .resp_rdata_o(resp_rdata_b), .resp_err_o(resp_err_b)
  );

  int checks   = 0;
  int failures = 0;

  logic [63:0] model_a [longint];
  logic [63:0] model_b [longint];

  typedef struct {
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
  } op_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } resp_t;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_err(input logic [63:0] addr);
    return (addr < BASE) || (((addr - BASE) / 64'd8) >= 64'(DEPTH));
  endfunction

  function automatic longint widx(input logic [63:0] addr);
    return longint'((addr - BASE) / 64'd8);
  endfunction

  function automatic logic [63:0] lane_merge(input logic [63:0] old_w, input logic [63:0] new_w,
                                             input logic [7:0] mask);
    logic [63:0] r;
    r = old_w;
    for (int k = 0; k < 8; k++) if (mask[k]) r[8*k +: 8] = new_w[8*k +: 8];
    return r;
  endfunction

  function automatic logic [63:0] rd_a(input longint ix);
    return model_a.exists(ix) ? model_a[ix] : 64'h0;
  endfunction

  function automatic logic [63:0] rd_b(input longint ix);
    return model_b.exists(ix) ? model_b[ix] : 64'h0;
  endfunction

  // One full transaction on instance a, holding resp_ready low for `hold` cycles after valid.
  task automatic txn_a(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [7:0] mask, input int hold, input string tag);
    logic        e;
    logic [63:0] er;
    longint      ix;
    int          lat;
    logic        seen;
    e  = exp_err(addr);
    ix = widx(addr);
    er = 64'h0;
    if (!wen && !e) er = rd_a(ix);
    if (wen && !e) model_a[ix] = lane_merge(rd_a(ix), wdata, mask);
    @(negedge clk);
    chk({tag, "_ready_idle"}, 64'(req_ready_a), 64'd1);
    req_valid_a = 1'b1; req_wen_a = wen; req_addr_a = addr;
    req_wdata_a = wdata; req_wmask_a = mask; resp_ready_a = (hold == 0);
    @(posedge clk); #1;
    // Garbage request while busy: must be ignored.
    req_valid_a = 1'($urandom_range(0, 1)); req_wen_a = 1'b1; req_addr_a = BASE + 64'h10;
    req_wdata_a = {$urandom, $urandom}; req_wmask_a = 8'hFF;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      seen = resp_valid_a;
      chk({tag, "_ready_busy"}, 64'(req_ready_a), 64'd0);
    end
    chk({tag, "_latency"}, 64'(lat), 64'(LAT_A));
    chk({tag, "_rdata"}, resp_rdata_a, er);
    chk({tag, "_err"}, 64'(resp_err_a), 64'(e));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 64'(resp_valid_a), 64'd1);
      chk({tag, "_hold_rdata"}, resp_rdata_a, er);
      chk({tag, "_hold_err"}, 64'(resp_err_a), 64'(e));
      chk({tag, "_hold_ready"}, 64'(req_ready_a), 64'd0);
    end
    resp_ready_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0; resp_ready_a = 1'b0;
    @(negedge clk);
    chk({tag, "_valid_drop"}, 64'(resp_valid_a), 64'd0);
    chk({tag, "_ready_back"}, 64'(req_ready_a), 64'd1);
  endtask

  // Accept a request on instance a, then assert rst while it is still in WAIT.
  task automatic rst_mid(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                         input string tag);
    if (wen && !exp_err(addr)) model_a[widx(addr)] = wdata;
    @(negedge clk);
    req_valid_a = 1'b1; req_wen_a = wen; req_addr_a = addr;
    req_wdata_a = wdata; req_wmask_a = 8'hFF; resp_ready_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    rst = 1'b1;
    #1;
    chk({tag, "_rst_valid"}, 64'(resp_valid_a), 64'd0);
    chk({tag, "_rst_ready"}, 64'(req_ready_a), 64'd0);
    chk({tag, "_rst_rdata"}, resp_rdata_a, 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk({tag, "_post_valid"}, 64'(resp_valid_a), 64'd0);
      chk({tag, "_post_ready"}, 64'(req_ready_a), 64'd1);
    end
    resp_ready_a = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint      pool [8];
    logic [63:0] err_pool [6];
    op_t         ops [$];
    resp_t       expq [$];
    op_t         op;
    resp_t       rsp;
    logic [63:0] addr;
    int          cyc, nresp, last_resp, nops, oi;
    logic        acc;

    pool = '{0, 1, 2, 3, 37, DEPTH / 2, DEPTH - 2, DEPTH - 1};
    err_pool = '{BASE - 64'd8, BASE + 64'(8 * DEPTH), 64'h0, 64'hFFFF_FFFF_FFFF_FFF8,
                 BASE - 64'd1, BASE + 64'(8 * DEPTH) + 64'd8};

    req_valid_a = 1'b0; req_wen_a = 1'b0; req_addr_a = 64'h0; req_wdata_a = 64'h0;
    req_wmask_a = 8'h0; resp_ready_a = 1'b0;
    req_valid_b = 1'b0; req_wen_b = 1'b0; req_addr_b = 64'h0; req_wdata_b = 64'h0;
    req_wmask_b = 8'h0; resp_ready_b = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_ready_a", 64'(req_ready_a), 64'd0);
    chk("rst_valid_a", 64'(resp_valid_a), 64'd0);
    chk("rst_rdata_a", resp_rdata_a, 64'h0);
    chk("rst_err_a", 64'(resp_err_a), 64'd0);
    chk("rst_ready_b", 64'(req_ready_b), 64'd0);
    chk("rst_valid_b", 64'(resp_valid_b), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready_a", 64'(req_ready_a), 64'd1);
    chk("post_rst_ready_b", 64'(req_ready_b), 64'd1);

    // Preload every pool word so later partial writes/reads have known contents.
    foreach (pool[i]) txn_a(1'b1, BASE + 64'(pool[i]) * 64'd8, {$urandom, $urandom}, 8'hFF, 0, "preload");

    // Directed: full write, readback, partial overwrite, no-op mask.
    txn_a(1'b1, BASE + 64'h10, 64'h1122_3344_5566_7788, 8'hFF, 0, "wr_full");
    txn_a(1'b0, BASE + 64'h10, 64'h0, 8'h00, 0, "rd_full");
    chk("model_full", rd_a(2), 64'h1122_3344_5566_7788);
    txn_a(1'b1, BASE + 64'h10, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 0, "wr_part");
    txn_a(1'b0, BASE + 64'h10, 64'h0, 8'h00, 1, "rd_part");
    chk("model_part", rd_a(2), 64'h1122_3344_AAAA_AAAA);
    txn_a(1'b1, BASE + 64'h10, 64'h5555_5555_5555_5555, 8'h00, 0, "wr_nomask");
    txn_a(1'b0, BASE + 64'h17, 64'h0, 8'h00, 0, "rd_nomask");

    // Directed: out-of-range reads and writes.
    txn_a(1'b0, 64'h7FFF_FFF8, 64'h0, 8'h00, 0, "rd_below");
    txn_a(1'b0, BASE + 64'(8 * DEPTH), 64'h0, 8'h00, 0, "rd_above");
    txn_a(1'b1, BASE + 64'(8 * DEPTH), 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 0, "wr_above");
    txn_a(1'b1, 64'h7FFF_FFF8, 64'hCAFE_F00D_CAFE_F00D, 8'hFF, 0, "wr_below");
    txn_a(1'b0, BASE, 64'h0, 8'h00, 0, "rd_word0");
    txn_a(1'b0, BASE + 64'(8 * (DEPTH - 1)), 64'h0, 8'h00, 0, "rd_wordlast");

    // Directed: response held for 5 cycles.
    txn_a(1'b0, BASE + 64'h10, 64'h0, 8'h00, 5, "hold5");

    // Directed: reset during WAIT for a read, then for a write.
    rst_mid(1'b0, BASE + 64'h10, 64'h0, "rst_rd");
    txn_a(1'b0, BASE + 64'h10, 64'h0, 8'h00, 0, "rd_after_rst");
    rst_mid(1'b1, BASE + 64'h18, 64'h0BAD_F00D_1234_5678, "rst_wr");
    txn_a(1'b0, BASE + 64'h18, 64'h0, 8'h00, 0, "rd_committed");

    // Back-to-back on instance b (LATENCY=1): one response every 2 cycles, in order.
    for (int i = 0; i < 4; i++) ops.push_back('{1'b1, BASE + 64'(8 * (5 + i)), {$urandom, $urandom}});
    ops.push_back('{1'b0, BASE + 64'(8 * 8), 64'h0});
    ops.push_back('{1'b0, BASE + 64'(8 * 5), 64'h0});
    ops.push_back('{1'b0, BASE + 64'(8 * 7), 64'h0});
    ops.push_back('{1'b0, BASE - 64'd8, 64'h0});
    ops.push_back('{1'b0, BASE + 64'(8 * 6), 64'h0});
    nops = ops.size();
    @(negedge clk);
    resp_ready_b = 1'b1; req_wmask_b = 8'hFF;
    oi = 0;
    req_valid_b = 1'b1; req_wen_b = ops[0].wen; req_addr_b = ops[0].addr; req_wdata_b = ops[0].wdata;
    cyc = 0; nresp = 0; last_resp = -1;
    while (nresp < nops && cyc < 200) begin
      if (resp_valid_b) begin
        if (expq.size() == 0) begin
          chk("b2b_spurious", 64'(resp_valid_b), 64'd0);
        end else begin
          rsp = expq.pop_front();
          chk("b2b_rdata", resp_rdata_b, rsp.rdata);
          chk("b2b_err", 64'(resp_err_b), 64'(rsp.err));
          if (last_resp >= 0) chk("b2b_gap", 64'(cyc - last_resp), 64'd2);
        end
        last_resp = cyc;
        nresp++;
      end
      acc = req_ready_b && req_valid_b;
      if (acc) begin
        op = ops[oi];
        rsp.err = exp_err(op.addr);
        rsp.rdata = (op.wen || rsp.err) ? 64'h0 : rd_b(widx(op.addr));
        if (op.wen && !rsp.err) model_b[widx(op.addr)] = op.wdata;
        expq.push_back(rsp);
        oi++;
      end
      @(posedge clk); #1;
      if (acc) begin
        if (oi < nops) begin
          req_wen_b = ops[oi].wen; req_addr_b = ops[oi].addr; req_wdata_b = ops[oi].wdata;
        end else begin
          req_valid_b = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    chk("b2b_count", 64'(nresp), 64'(nops));
    resp_ready_b = 1'b0; req_valid_b = 1'b0;

    // Randomized traffic on instance a.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        addr = err_pool[$urandom_range(0, 5)];
      end else begin
        addr = BASE + 64'(pool[$urandom_range(0, 7)]) * 64'd8 + 64'($urandom_range(0, 7));
      end
      txn_a(1'($urandom_range(0, 1)), addr, {$urandom, $urandom}, 8'($urandom_range(0, 255)),
            $urandom_range(0, 3), "rand");
    end

    // Final sweep: every pool word must match the model.
    foreach (pool[i]) txn_a(1'b0, BASE + 64'(pool[i]) * 64'd8, 64'h0, 8'h00, 0, "sweep");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
